// File: rtl/pp_accum_mult_pkg.sv
// Shared definitions for the sequential shift-accumulate multipliers.
// Provides the FSM state type, the supported operand-width range and a
// helper that sizes the step counter.
package pp_accum_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Step counter width: $clog2(w), never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/pp_row.sv
// Single partial-product row: WIDTH two-input AND gates gating the
// multiplicand with one multiplier bit.
// Ports:
//   mcand   in  WIDTH  multiplicand
//   bit_sel in  1      selected multiplier bit
//   pp      out WIDTH  mcand & {WIDTH{bit_sel}}
module pp_row #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic             bit_sel,
  output logic [WIDTH-1:0] pp
);

  assign pp = mcand & {WIDTH{bit_sel}};

endmodule

// File: rtl/pp_accum_mult.sv
// Sequential unsigned multiplier: one partial-product row per clock is
// shifted into place and added to a 2*WIDTH accumulator. Valid/ready
// handshakes on both sides; a single operation is in flight at a time.
// Ports:
//   clk       in  1        clock, rising edge
//   rst_n     in  1        synchronous active-low reset
//   in_valid  in  1        operands a/b valid
//   in_ready  out 1        ready to accept operands (IDLE)
//   a         in  WIDTH    multiplicand, unsigned
//   b         in  WIDTH    multiplier, unsigned
//   out_valid out 1        product p valid (DONE)
//   out_ready in  1        consumer accepts p
//   p         out 2*WIDTH  product a*b, held until the next result
//   busy      out 1        high in RUN or DONE
module pp_accum_mult
  import pp_accum_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned CW = cnt_bits(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pp;
  logic [PW-1:0]    acc_next;

  pp_row #(.WIDTH(WIDTH)) u_row (
    .mcand   (mcand),
    .bit_sel (mplier[cnt]),
    .pp      (pp)
  );

  always_comb begin
    acc_next = acc + (PW'(pp) << cnt);
  end

  // Handshake flags are registered alongside the state so that each one
  // changes on exactly the edge that moves the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p         <= '0;
      acc       <= '0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            mplier   <= b;
            acc      <= '0;
            cnt      <= '0;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          if (cnt == LAST_STEP) begin
            // Final row folds straight into p so DONE presents it at once.
            p         <= acc_next;
            cnt       <= '0;
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_accum_mult.sv
// Bench for pp_accum_mult: an 8-bit instance for directed cases and a
// 4-bit instance for the exhaustive back-to-back sweep. A cycle-level
// model (operation countdown plus a*b) is checked against both DUTs on
// every falling edge once reset has been applied.
module tb_pp_accum_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_ready;

  logic        v8, ir8, ov8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        v4, ir4, ov4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // model state per instance: 0 idle, 1 running, 2 result waiting
  int          ph[2];
  int          left[2];
  logic [31:0] ex[2];
  logic [31:0] mp[2];
  logic        iv[2];
  logic [31:0] ia[2], ib[2];
  int          wd[2];

  int n4 = 0;
  int last_rise = -1;
  logic prev_ov4 = 1'b0;

  pp_accum_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(out_ready), .p(p8), .busy(busy8)
  );

  pp_accum_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(out_ready), .p(p4), .busy(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    iv[0] = v8; ia[0] = 32'(a8); ib[0] = 32'(b8);
    iv[1] = v4; ia[1] = 32'(a4); ib[1] = 32'(b4);
  end

  initial begin
    wd[0] = 8; wd[1] = 4;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; left[k] = 0; ex[k] = 0; mp[k] = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Model: accept in idle, result appears WIDTH edges after the accepting
  // edge, released by out_ready; reset clears everything.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k] <= 0;
        mp[k] <= 0;
      end else begin
        case (ph[k])
          0: if (iv[k]) begin
            ex[k]   <= ia[k] * ib[k];
            left[k] <= wd[k];
            ph[k]   <= 1;
          end
          1: begin
            left[k] <= left[k] - 1;
            if (left[k] == 1) begin
              ph[k] <= 2;
              mp[k] <= ex[k];
            end
          end
          default: if (out_ready) ph[k] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready8",  32'(ir8),   32'(ph[0] == 0));
      chk("m_busy8",      32'(busy8), 32'(ph[0] != 0));
      chk("m_out_valid8", 32'(ov8),   32'(ph[0] == 2));
      chk("m_p8",         32'(p8),    mp[0]);
      chk("m_in_ready4",  32'(ir4),   32'(ph[1] == 0));
      chk("m_busy4",      32'(busy4), 32'(ph[1] != 0));
      chk("m_out_valid4", 32'(ov4),   32'(ph[1] == 2));
      chk("m_p4",         32'(p4),    mp[1]);
      if (ov4 && !prev_ov4) begin
        n4++;
        if (last_rise >= 0) chk("t6_spacing", 32'(cyc - last_rise), 32'd6);
        last_rise = cyc;
      end
    end
    prev_ov4 = ov4;
  end

  // lat counts edges including the accepting one.
  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     output logic [15:0] res, output int lat);
    int g;
    g = 0;
    while (!ir8 && g < 50) begin @(posedge clk); #1; g++; end
    if (!ir8) timeout_fail("op8_ready");
    a8 = x; b8 = y; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!ov8) timeout_fail("op8_done");
    res = p8;
  endtask

  initial begin
    logic [15:0] r;
    int          l;
    int          g;
    logic        saw_ov;

    rst_n = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0;
    v4 = 1'b0; a4 = '0; b4 = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("t1_in_ready8", 32'(ir8), 32'd1);
    chk("t1_out_valid8", 32'(ov8), 32'd0);
    chk("t1_busy8", 32'(busy8), 32'd0);
    chk("t1_p8", 32'(p8), 32'd0);
    chk("t1_in_ready4", 32'(ir4), 32'd1);
    chk("t1_out_valid4", 32'(ov4), 32'd0);
    chk("t1_busy4", 32'(busy4), 32'd0);
    chk("t1_p4", 32'(p4), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // max operands
    op8(8'hFF, 8'hFF, r, l);
    chk("t2_p", 32'(r), 32'h0000FE01);
    chk("t2_latency", 32'(l), 32'd9);
    @(posedge clk); #1;

    // backpressure, ignored in_valid while busy
    out_ready = 1'b0;
    op8(8'd13, 8'd11, r, l);
    chk("t3_p", 32'(r), 32'd143);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin a8 = 8'd2; b8 = 8'd2; v8 = 1'b1; end
      else v8 = 1'b0;
      @(posedge clk); #1;
      chk("t3_hold_p", 32'(p8), 32'd143);
      chk("t3_hold_ov", 32'(ov8), 32'd1);
      chk("t3_in_ready", 32'(ir8), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_ov", 32'(ov8), 32'd0);
    chk("t3_release_rdy", 32'(ir8), 32'd1);
    op8(8'd3, 8'd5, r, l);
    chk("t3_next_p", 32'(r), 32'd15);
    @(posedge clk); #1;

    // zero operands take the full latency
    op8(8'd0, 8'd200, r, l);
    chk("t4_p_a0", 32'(r), 32'd0);
    chk("t4_lat_a0", 32'(l), 32'd9);
    @(posedge clk); #1;
    op8(8'd200, 8'd0, r, l);
    chk("t4_p_b0", 32'(r), 32'd0);
    chk("t4_lat_b0", 32'(l), 32'd9);
    @(posedge clk); #1;

    // abort mid-RUN
    a8 = 8'd9; b8 = 8'd9; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_ov", 32'(ov8), 32'd0);
    chk("t5_ready", 32'(ir8), 32'd1);
    chk("t5_busy", 32'(busy8), 32'd0);
    saw_ov = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (ov8) saw_ov = 1'b1; end
    chk("t5_no_result", 32'(saw_ov), 32'd0);
    op8(8'd7, 8'd6, r, l);
    chk("t5_p", 32'(r), 32'd42);
    chk("t5_latency", 32'(l), 32'd9);
    @(posedge clk); #1;

    // exhaustive 4-bit sweep, back-to-back
    out_ready = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y); v4 = 1'b1;
        g = 0;
        while (!ir4 && g < 20) begin @(posedge clk); #1; g++; end
        if (!ir4) timeout_fail("t6_ready");
        @(posedge clk); #1;
      end
    end
    v4 = 1'b0;
    g = 0;
    while (n4 < 256 && g < 50) begin @(posedge clk); #1; g++; end
    chk("t6_count", 32'(n4), 32'd256);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
